ber_accumulator: RTL and testbench

BER_ACCUMULATOR -- requirements
Module: ber_accumulator

---
 rtl/ber_accumulator.sv | 151 +++++++++++++++
 tb/tb_ber_accumulator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ber_accumulator.sv
// Bit-error-rate accumulator: counts bits, words and bit errors from a PRBS checker
// over a start/stop or fixed-length window, tracking lock drops along the way.
module ber_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 48,
  parameter int ERR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             lock,
  input  logic [WIDTH:0]   err_num,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] window_words,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      lock_loss_cnt,
  output logic             done,
  output logic             err_sat
);

  // state     | meaning
  // IDLE      | waiting for start
  // WAIT_LOCK | armed, waiting for checker lock; nothing counted
  // MEASURE   | counting qualifying words
  // DONE      | window/stop reached, counters frozen
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int SW = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_q, word_q;
  logic [ERR_W-1:0]   err_q;
  logic [15:0]        loss_q;
  logic               done_q, sat_q;

  logic               clear, count, lost;
  logic [CNT_W:0]     bit_sum, word_sum;
  logic [CNT_W-1:0]   bit_inc, word_inc;
  logic [WIDTH:0]     err_clamp;
  logic [SW-1:0]      err_sum;
  logic               err_ovf;
  logic [ERR_W-1:0]   err_inc;

  // Saturating next values; computed wide so overflow is visible as a carry.
  always_comb begin
    bit_sum   = {1'b0, bit_q} + (CNT_W + 1)'(WIDTH);
    word_sum  = {1'b0, word_q} + (CNT_W + 1)'(1);
    bit_inc   = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    word_inc  = word_sum[CNT_W] ? '1 : word_sum[CNT_W-1:0];
    err_clamp = (err_num > (WIDTH + 1)'(WIDTH)) ? (WIDTH + 1)'(WIDTH) : err_num;
    err_sum   = SW'(err_q) + SW'(err_clamp);
    err_ovf   = err_sum > SW'({ERR_W{1'b1}});
    err_inc   = err_ovf ? '1 : err_sum[ERR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    count   = 1'b0;
    lost    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (start) begin
          clear   = 1'b1;
          state_d = WAIT_LOCK;
        end else if (stop) begin
          state_d = DONE;
        end else if (lock) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = WAIT_LOCK;
        end else begin
          count = en & lock;
          lost  = ~lock;
          if (stop) begin
            state_d = DONE;
          end else if (!lock) begin
            state_d = WAIT_LOCK;
          end else if (count && window_words != '0 && word_inc == window_words) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = WAIT_LOCK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      bit_q   <= '0;
      word_q  <= '0;
      err_q   <= '0;
      loss_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      if (clear) begin
        bit_q  <= '0;
        word_q <= '0;
        err_q  <= '0;
        loss_q <= '0;
        sat_q  <= 1'b0;
      end else begin
        if (count) begin
          bit_q  <= bit_inc;
          word_q <= word_inc;
          err_q  <= err_inc;
          if (err_ovf) sat_q <= 1'b1;
        end
        if (lost && loss_q != 16'hFFFF) loss_q <= loss_q + 16'd1;
      end
    end
  end

  assign state         = state_q;
  assign bit_cnt       = bit_q;
  assign word_cnt      = word_q;
  assign err_cnt       = err_q;
  assign lock_loss_cnt = loss_q;
  assign done          = done_q;
  assign err_sat       = sat_q;

endmodule

// File: tb/tb_ber_accumulator.sv
// Directed bench for ber_accumulator: a default-size instance plus a narrow one
// (CNT_W=8, ERR_W=4) driven from the same stimulus to reach saturation quickly.
module tb_ber_accumulator;

  logic        clk = 1'b0;
  logic        reset, en, lock, start, stop;
  logic [8:0]  err_num;
  logic [47:0] window_words;
  logic [7:0]  window_small;

  logic [1:0]  state, state_s;
  logic [47:0] bit_cnt, word_cnt;
  logic [31:0] err_cnt;
  logic [15:0] lock_loss_cnt, lock_loss_s;
  logic        done, err_sat, done_s, sat_s;
  logic [7:0]  bit_s, word_s;
  logic [3:0]  err_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign window_small = window_words[7:0];

  ber_accumulator dut (
    .clk(clk), .reset(reset), .en(en), .lock(lock), .err_num(err_num),
    .start(start), .stop(stop), .window_words(window_words),
    .state(state), .bit_cnt(bit_cnt), .word_cnt(word_cnt), .err_cnt(err_cnt),
    .lock_loss_cnt(lock_loss_cnt), .done(done), .err_sat(err_sat)
  );

  ber_accumulator #(.WIDTH(8), .CNT_W(8), .ERR_W(4)) dut_s (
    .clk(clk), .reset(reset), .en(en), .lock(lock), .err_num(err_num),
    .start(start), .stop(stop), .window_words(window_small),
    .state(state_s), .bit_cnt(bit_s), .word_cnt(word_s), .err_cnt(err_s),
    .lock_loss_cnt(lock_loss_s), .done(done_s), .err_sat(sat_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [8:0] e);
    en      = 1'b1;
    err_num = e;
    tick();
    err_num = 9'd0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; lock = 1'b0; start = 1'b0; stop = 1'b0;
    err_num = 9'd0; window_words = 48'd100;
    tick(); tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_bit", 64'(bit_cnt), 64'd0);
    chk("rst_word", 64'(word_cnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sat", 64'(err_sat), 64'd0);
    reset = 1'b1;
    tick();
    chk("first_edge_idle", 64'(state), 64'd0);

    // basic 100-word window, no errors
    start = 1'b1; lock = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    chk("a_wait_lock", 64'(state), 64'd1);
    tick();
    chk("a_measure", 64'(state), 64'd2);
    chk("a_nothing_in_wait", 64'(word_cnt), 64'd0);
    for (int i = 1; i <= 100; i++) begin
      word(9'd0);
      if (i == 99) chk("a_not_done_99", 64'(state), 64'd2);
    end
    chk("a_state_done", 64'(state), 64'd3);
    chk("a_done", 64'(done), 64'd1);
    chk("a_bit", 64'(bit_cnt), 64'd800);
    chk("a_word", 64'(word_cnt), 64'd100);
    chk("a_err", 64'(err_cnt), 64'd0);
    word(9'd3); word(9'd3);
    chk("a_frozen_word", 64'(word_cnt), 64'd100);
    chk("a_frozen_err", 64'(err_cnt), 64'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("a_stop_in_done", 64'(state), 64'd3);

    // error accumulation with clamp; restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_restart_state", 64'(state), 64'd1);
    chk("b_cleared_word", 64'(word_cnt), 64'd0);
    chk("b_done_low", 64'(done), 64'd0);
    tick();
    for (int i = 1; i <= 100; i++) begin
      if (i == 10 || i == 20 || i == 30) word(9'd1);
      else if (i == 40) word(9'd9);
      else word(9'd0);
    end
    chk("b_err", 64'(err_cnt), 64'd11);
    chk("b_state", 64'(state), 64'd3);
    chk("b_small_err", 64'(err_s), 64'd11);
    chk("b_small_word", 64'(word_s), 64'd100);
    chk("b_small_bit_sat", 64'(bit_s), 64'd255);

    // lock loss for 3 cycles at word 50
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 1; i <= 49; i++) word(9'd0);
    lock = 1'b0;
    tick(); tick(); tick();
    chk("c_loss_cnt", 64'(lock_loss_cnt), 64'd1);
    chk("c_word_held", 64'(word_cnt), 64'd49);
    chk("c_state_wait", 64'(state), 64'd1);
    lock = 1'b1;
    tick();
    chk("c_relock", 64'(state), 64'd2);
    chk("c_relock_word", 64'(word_cnt), 64'd49);
    for (int i = 1; i <= 51; i++) begin
      word(9'd0);
      if (i == 50) chk("c_not_done", 64'(state), 64'd2);
    end
    chk("c_state_done", 64'(state), 64'd3);
    chk("c_word", 64'(word_cnt), 64'd100);
    chk("c_bit", 64'(bit_cnt), 64'd800);
    chk("c_loss_final", 64'(lock_loss_cnt), 64'd1);

    // en gap of 50 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 1; i <= 30; i++) word(9'd0);
    en = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("d_gap_word", 64'(word_cnt), 64'd30);
    chk("d_gap_bit", 64'(bit_cnt), 64'd240);
    for (int i = 1; i <= 70; i++) word(9'd0);
    chk("d_bit", 64'(bit_cnt), 64'd800);
    chk("d_done", 64'(done), 64'd1);

    // continuous mode, saturation on the narrow instance
    window_words = 48'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    word(9'd8);
    chk("e_err_8", 64'(err_s), 64'd8);
    chk("e_sat_low", 64'(sat_s), 64'd0);
    word(9'd8);
    chk("e_err_15", 64'(err_s), 64'd15);
    chk("e_sat_high", 64'(sat_s), 64'd1);
    word(9'd8);
    chk("e_err_stuck", 64'(err_s), 64'd15);
    chk("e_wide_err", 64'(err_cnt), 64'd24);
    for (int i = 4; i <= 300; i++) word(9'd0);
    chk("e_sat_sticky", 64'(sat_s), 64'd1);
    chk("e_word_300", 64'(word_cnt), 64'd300);
    chk("e_small_word_sat", 64'(word_s), 64'd255);
    chk("e_continuous", 64'(state), 64'd2);
    window_words = 48'd5;
    for (int i = 0; i < 5; i++) word(9'd0);
    chk("e_window_below", 64'(state), 64'd2);
    chk("e_window_word", 64'(word_cnt), 64'd305);
    stop = 1'b1;
    word(9'd0);
    stop = 1'b0;
    chk("e_stop_done", 64'(state), 64'd3);
    chk("e_stop_counted", 64'(word_cnt), 64'd306);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e_clr_err", 64'(err_s), 64'd0);
    chk("e_clr_sat", 64'(sat_s), 64'd0);

    // reset mid-measurement at word 37
    window_words = 48'd100;
    tick();
    for (int i = 1; i <= 37; i++) word(9'd1);
    chk("f_word_37", 64'(word_cnt), 64'd37);
    reset = 1'b0; start = 1'b1;
    tick();
    reset = 1'b1; start = 1'b0;
    chk("f_rst_state", 64'(state), 64'd0);
    chk("f_rst_word", 64'(word_cnt), 64'd0);
    chk("f_rst_err", 64'(err_cnt), 64'd0);
    stop = 1'b1;
    tick();
    chk("f_stop_idle", 64'(state), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("f_start_over_stop", 64'(state), 64'd1);
    tick();
    for (int i = 1; i <= 5; i++) word(9'd0);
    chk("f_pre_restart", 64'(word_cnt), 64'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f_restart_state", 64'(state), 64'd1);
    chk("f_restart_word", 64'(word_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
